// File: rtl/muldiv_sched_if.sv
// EX-stage <-> multiply/divide sequencer handshake and result bus.
interface muldiv_sched_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start_i;
  logic [1:0]       op_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             flush_i;
  logic             stall_ext_i;
  logic             stall_req_o;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;

  modport master (
    output start_i, op_i, a_i, b_i, flush_i, stall_ext_i,
    input  stall_req_o, busy_o, done_o, hi_o, lo_o
  );

  modport slave (
    input  start_i, op_i, a_i, b_i, flush_i, stall_ext_i,
    output stall_req_o, busy_o, done_o, hi_o, lo_o
  );
endinterface

// File: rtl/muldiv_sched.sv
// Shared MULT/MULTU/DIV/DIVU sequencer: one-cycle registered multiply,
// WIDTH-cycle radix-2 restoring divide, {HI,LO} result held in DONE.
module muldiv_sched #(
  parameter int unsigned WIDTH = 32
) (
  input  logic           clk,
  input  logic           resetn,
  muldiv_sched_if.slave  bus
);
  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] mag_a_q, mag_a_d;   // dividend magnitude, shifts into quotient
  logic [WIDTH-1:0] mag_b_q, mag_b_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             qneg_q, qneg_d;     // quotient / product sign
  logic             rneg_q, rneg_d;     // remainder sign
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic             accept;
  logic             is_signed, sign_a, sign_b;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   rem_nx;
  logic [WIDTH-1:0] quo_nx;
  logic             ge;
  logic [PW-1:0]    prod;
  logic [PW-1:0]    prod_fix;

  assign accept          = (state_q == S_IDLE) && bus.start_i && !bus.flush_i;
  assign bus.stall_req_o = accept || (state_q == S_MUL) || (state_q == S_DIV);
  assign bus.busy_o      = (state_q != S_IDLE);
  assign bus.done_o      = (state_q == S_DONE);
  assign bus.hi_o        = hi_q;
  assign bus.lo_o        = lo_q;

  // Operand sign decode and one restoring-divide / multiply datapath step.
  always_comb begin
    is_signed = ~bus.op_i[0];
    sign_a    = is_signed & bus.a_i[WIDTH-1];
    sign_b    = is_signed & bus.b_i[WIDTH-1];
    trial     = {rem_q, mag_a_q[WIDTH-1]};
    ge        = (trial >= {1'b0, mag_b_q});
    rem_nx    = ge ? (trial - {1'b0, mag_b_q}) : trial;
    quo_nx    = {mag_a_q[WIDTH-2:0], ge};
    prod      = PW'(mag_a_q) * PW'(mag_b_q);
    prod_fix  = qneg_q ? (PW'(0) - prod) : prod;
  end

  // Next-state and register-update logic.
  always_comb begin
    state_d = state_q;
    mag_a_d = mag_a_q;
    mag_b_d = mag_b_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          mag_a_d = sign_a ? (WIDTH'(0) - bus.a_i) : bus.a_i;
          mag_b_d = sign_b ? (WIDTH'(0) - bus.b_i) : bus.b_i;
          qneg_d  = sign_a ^ sign_b;
          rneg_d  = sign_a;
          rem_d   = '0;
          cnt_d   = '0;
          state_d = bus.op_i[1] ? S_DIV : S_MUL;
        end
      end
      S_MUL: begin
        hi_d    = prod_fix[PW-1:WIDTH];
        lo_d    = prod_fix[WIDTH-1:0];
        state_d = S_DONE;
      end
      S_DIV: begin
        mag_a_d = quo_nx;
        rem_d   = rem_nx[WIDTH-1:0];
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST_ITER) begin
          // Divide by zero leaves quotient all-ones; the remainder path
          // already reproduces the raw dividend.
          if (mag_b_q == '0) begin
            lo_d = '1;
          end else begin
            lo_d = qneg_q ? (WIDTH'(0) - quo_nx) : quo_nx;
          end
          hi_d    = rneg_q ? (WIDTH'(0) - rem_nx[WIDTH-1:0]) : rem_nx[WIDTH-1:0];
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (!bus.stall_ext_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Flush aborts from any state without touching HI/LO.
    if (bus.flush_i) begin
      state_d = S_IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      mag_a_q <= '0;
      mag_b_q <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      mag_a_q <= mag_a_d;
      mag_b_q <= mag_b_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end
endmodule

// File: tb/tb_muldiv_sched.sv
// Directed vector bench for muldiv_sched.
module tb_muldiv_sched;
  localparam int unsigned W = 32;

  logic clk;
  logic resetn;
  int   total  = 0;
  int   passed = 0;

  muldiv_sched_if #(.WIDTH(W)) bus();

  muldiv_sched #(.WIDTH(W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Issue one operation, wait (bounded) for done_o and check the result.
  task automatic run_op(input vec_t v, input string tag);
    int   lat;
    int   stall_cnt;
    logic got;
    tick();
    bus.start_i = 1'b1;
    bus.op_i    = v.op;
    bus.a_i     = v.a;
    bus.b_i     = v.b;
    sample();
    check({tag, " stall_at_T"}, 64'(bus.stall_req_o), 64'(1));
    lat = -1;
    stall_cnt = 0;
    got = 1'b0;
    for (int c = 1; c <= 60 && !got; c++) begin
      tick();
      bus.start_i = 1'b0;
      bus.a_i     = $urandom();
      bus.b_i     = $urandom();
      sample();
      if (bus.done_o) begin
        got = 1'b1;
        lat = c;
      end else if (bus.stall_req_o) begin
        stall_cnt++;
      end
    end
    check({tag, " latency"}, 64'(lat), 64'(v.lat));
    check({tag, " stall_cycles"}, 64'(stall_cnt), 64'(v.lat - 1));
    check({tag, " stall_in_done"}, 64'(bus.stall_req_o), 64'(0));
    check({tag, " hi"}, 64'(bus.hi_o), 64'(v.hi));
    check({tag, " lo"}, 64'(bus.lo_o), 64'(v.lo));
    tick();
    sample();
    check({tag, " idle_after"}, 64'({bus.busy_o, bus.done_o}), 64'(0));
  endtask

  initial begin
    logic [31:0] hi0, lo0;
    logic        seen_done;
    int          lat;

    vecs[0] = '{2'b00, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 2};
    vecs[1] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 2};
    vecs[2] = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 33};
    vecs[3] = '{2'b11, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 33};
    vecs[4] = '{2'b11, 32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF, 33};
    vecs[5] = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33};
    vecs[6] = '{2'b10, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 33};
    vecs[7] = '{2'b00, 32'h00000007, 32'hFFFFFFFB, 32'hFFFFFFFF, 32'hFFFFFFDD, 2};
    vecs[8] = '{2'b01, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 2};
    vecs[9] = '{2'b10, 32'h00000064, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFF2, 33};

    resetn          = 1'b0;
    bus.start_i     = 1'b0;
    bus.op_i        = 2'b00;
    bus.a_i         = '0;
    bus.b_i         = '0;
    bus.flush_i     = 1'b0;
    bus.stall_ext_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset flags", 64'({bus.busy_o, bus.done_o, bus.stall_req_o}), 64'(0));
    check("reset hi", 64'(bus.hi_o), 64'(0));
    check("reset lo", 64'(bus.lo_o), 64'(0));
    resetn = 1'b1;

    for (int i = 0; i < 10; i++) run_op(vecs[i], $sformatf("vec%0d", i));

    // Flush mid-divide at T+10, then a fresh start at T+12.
    hi0 = bus.hi_o;
    lo0 = bus.lo_o;
    seen_done = 1'b0;
    tick();
    bus.start_i = 1'b1; bus.op_i = 2'b11; bus.a_i = 32'd100; bus.b_i = 32'd3;
    for (int k = 1; k <= 11; k++) begin
      tick();
      bus.start_i = 1'b0;
      bus.flush_i = (k == 10);
      sample();
      if (bus.done_o) seen_done = 1'b1;
      if (k == 9) check("flush busy_before", 64'(bus.busy_o), 64'(1));
    end
    check("flush no_done", 64'(seen_done), 64'(0));
    check("flush idle", 64'({bus.busy_o, bus.stall_req_o}), 64'(0));
    check("flush hi_kept", 64'(bus.hi_o), 64'(hi0));
    check("flush lo_kept", 64'(bus.lo_o), 64'(lo0));
    run_op(vecs[3], "after_flush");

    // stall_ext_i holds the result in DONE for T+2..T+5.
    tick();
    bus.start_i = 1'b1; bus.op_i = 2'b00; bus.a_i = 32'd5; bus.b_i = 32'd6;
    bus.stall_ext_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    for (int k = 2; k <= 5; k++) begin
      tick();
      if (k == 5) bus.stall_ext_i = 1'b0;
      sample();
      check($sformatf("hold done_T+%0d", k), 64'(bus.done_o), 64'(1));
      check($sformatf("hold lo_T+%0d", k), 64'({bus.hi_o, bus.lo_o}), 64'h0000_0000_0000_001E);
      if (k == 3) check("hold stall_req", 64'(bus.stall_req_o), 64'(0));
    end
    tick();
    sample();
    check("hold exit", 64'({bus.busy_o, bus.done_o}), 64'(0));

    // start_i during a divide is ignored.
    tick();
    bus.start_i = 1'b1; bus.op_i = 2'b11; bus.a_i = 32'd7; bus.b_i = 32'd2;
    lat = -1;
    for (int c = 1; c <= 60 && lat < 0; c++) begin
      tick();
      bus.start_i = (c == 5);
      if (c == 5) begin
        bus.op_i = 2'b01; bus.a_i = 32'd9; bus.b_i = 32'd9;
      end
      sample();
      if (bus.done_o) lat = c;
    end
    check("ignore latency", 64'(lat), 64'(33));
    check("ignore result", 64'({bus.hi_o, bus.lo_o}), 64'h0000_0001_0000_0003);
    tick();

    // start_i together with flush_i in IDLE: nothing captured.
    lo0 = bus.lo_o;
    tick();
    bus.start_i = 1'b1; bus.flush_i = 1'b1; bus.op_i = 2'b01; bus.a_i = 32'd2; bus.b_i = 32'd2;
    sample();
    check("startflush stall", 64'(bus.stall_req_o), 64'(0));
    tick();
    bus.start_i = 1'b0; bus.flush_i = 1'b0;
    sample();
    check("startflush idle", 64'(bus.busy_o), 64'(0));
    tick();
    sample();
    check("startflush lo", 64'(bus.lo_o), 64'(lo0));

    // Flush in the DONE exit cycle: done_o still high that cycle.
    tick();
    bus.start_i = 1'b1; bus.op_i = 2'b01; bus.a_i = 32'd3; bus.b_i = 32'd4;
    tick();
    bus.start_i = 1'b0;
    tick();
    bus.flush_i = 1'b1; bus.stall_ext_i = 1'b1;
    sample();
    check("doneflush done", 64'(bus.done_o), 64'(1));
    check("doneflush lo", 64'(bus.lo_o), 64'(12));
    tick();
    bus.flush_i = 1'b0; bus.stall_ext_i = 1'b0;
    sample();
    check("doneflush exit", 64'({bus.busy_o, bus.done_o}), 64'(0));

    // Asynchronous reset at T+5 of a divide.
    tick();
    bus.start_i = 1'b1; bus.op_i = 2'b10; bus.a_i = 32'hFFFFFFF9; bus.b_i = 32'd2;
    for (int k = 1; k <= 5; k++) begin
      tick();
      bus.start_i = 1'b0;
    end
    check("midreset busy_before", 64'(bus.busy_o), 64'(1));
    resetn = 1'b0;
    #1;
    check("midreset flags", 64'({bus.busy_o, bus.done_o, bus.stall_req_o}), 64'(0));
    check("midreset hilo", 64'({bus.hi_o, bus.lo_o}), 64'(0));
    tick();
    resetn = 1'b1;
    sample();
    check("midreset idle", 64'(bus.busy_o), 64'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
